// File: rtl/irq_ctrl.sv
// ----------------------------------------------------------------------------
// irq_ctrl -- memory-mapped interrupt controller
//
// Collects up to eight peripheral requests into a pending register, gates
// them with a software mask and presents the lowest-index enabled request to
// the core as a vector. Reading VEC acknowledges the request and enters
// service. Writing EOI ends service.
//
// Register window (addr_i):
//   0 PEND  read: pending bits           write: 1 clears a bit
//   1 MASK  read/write, 1 = source enabled
//   2 VEC   read: {1, 0000, idx} in ASSERT (acknowledges), else 0x00
//   3 EOI   read: one-hot in-service bits  write: end of service
//
// Ports:
//   clk_i    single clock
//   rst_i    asynchronous, active-high reset
//   src_i    peripheral requests, synchronous to clk_i
//   sel_i    register access strobe
//   we_i     1 = write, 0 = read (only meaningful with sel_i)
//   addr_i   register select
//   wdata_i  write data
//   rdata_o  registered read data, held until the next read
//   irq_o    registered interrupt request to the core
//
// Build option:
//   IRQ_EDGE_EN  when defined, a source sets its pending bit only on a 0->1
//                transition (one-cycle history register). When undefined,
//                a high level sets the pending bit every cycle.
// ----------------------------------------------------------------------------
module irq_ctrl #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               sel_i,
  input  logic               we_i,
  input  logic [1:0]         addr_i,
  input  logic [7:0]         wdata_i,
  output logic [7:0]         rdata_o,
  output logic               irq_o
);

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_VEC  = 2'd2;
  localparam logic [1:0] ADDR_EOI  = 2'd3;

  // Register bits above NUM_SRC-1 are never stored and always read as 0.
  localparam logic [7:0] SRC_VALID = 8'((9'd1 << NUM_SRC) - 9'd1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] pend_q,  pend_d;
  logic [7:0] mask_q,  mask_d;
  logic [7:0] insvc_q, insvc_d;
  logic [7:0] rdata_q, rdata_d;
  logic       irq_q,   irq_d;

  logic [7:0] src_ext;
  logic [7:0] src_set;
  logic [7:0] cand_q;
  logic [2:0] win_idx;
  logic [7:0] win_onehot;
  logic       rd_en;
  logic       wr_en;
  logic       vec_ack;
  logic       eoi_wr;
  logic [7:0] clr_bits;

  assign src_ext = 8'(src_i) & SRC_VALID;

`ifdef IRQ_EDGE_EN
  // One-cycle history of the request lines; a bit is set only on 0->1.
  logic [7:0] hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= 8'h00;
    end else begin
      hist_q <= src_ext;
    end
  end

  assign src_set = src_ext & ~hist_q;
`else
  assign src_set = src_ext;
`endif

  // Candidates and the fixed-priority winner, lowest index first. The
  // winner is re-evaluated every cycle, so the vector reflects the state at
  // the moment of the VEC read rather than at assertion.
  assign cand_q = pend_q & mask_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise synthesis infers a latch.
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (cand_q[i]) begin
        win_idx = 3'(i);
      end
    end
  end

  assign win_onehot = 8'd1 << win_idx;

  assign rd_en   = sel_i & ~we_i;
  assign wr_en   = sel_i &  we_i;
  assign vec_ack = rd_en && (addr_i == ADDR_VEC) && (state_q == ST_ASSERT);
  assign eoi_wr  = wr_en && (addr_i == ADDR_EOI) && (state_q == ST_SERVICE);

  // Bits to clear this cycle: software W1C plus the acknowledged vector.
  assign clr_bits = ((wr_en && (addr_i == ADDR_PEND)) ? wdata_i : 8'h00)
                  | (vec_ack ? win_onehot : 8'h00);

  always_comb begin
    // A new request in the same cycle as a clear wins, so set is OR-ed last.
    pend_d  = ((pend_q & ~clr_bits) | src_set) & SRC_VALID;
    mask_d  = mask_q;
    insvc_d = insvc_q;
    rdata_d = rdata_q;
    state_d = state_q;

    if (wr_en && (addr_i == ADDR_MASK)) begin
      mask_d = wdata_i & SRC_VALID;
    end

    if (vec_ack) begin
      insvc_d = win_onehot;
    end else if (eoi_wr) begin
      insvc_d = 8'h00;
    end

    if (rd_en) begin
      case (addr_i)
        ADDR_PEND: rdata_d = pend_q;
        ADDR_MASK: rdata_d = mask_q;
        ADDR_VEC:  rdata_d = (state_q == ST_ASSERT) ? {1'b1, 4'b0000, win_idx}
                                                    : 8'h00;
        default:   rdata_d = insvc_q;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (cand_q != 8'h00) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Withdrawal looks at next-state PEND/MASK so that a mask write or
        // W1C drops irq_o on the very next edge.
        if (vec_ack) begin
          state_d = ST_SERVICE;
        end else if ((pend_d & mask_d) == 8'h00) begin
          state_d = ST_IDLE;
        end
      end
      ST_SERVICE: begin
        if (eoi_wr) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    irq_d = (state_d == ST_ASSERT);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      pend_q  <= 8'h00;
      mask_q  <= 8'h00;
      insvc_q <= 8'h00;
      rdata_q <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of all the others.
      state_q <= state_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      insvc_q <= insvc_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata_o = rdata_q;
  assign irq_o   = irq_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_irq_ctrl -- self-checking bench for irq_ctrl (NUM_SRC = 8)
//
// Register reads push their expected value onto a scoreboard queue; a monitor
// pops and compares once rdata_o becomes valid one edge later. irq_o is
// checked inline in each scenario task. Inputs change 1 time unit after the
// rising edge and outputs are sampled at the same point.
// ----------------------------------------------------------------------------
module tb_irq_ctrl;

  localparam logic [1:0] A_PEND = 2'd0;
  localparam logic [1:0] A_MASK = 2'd1;
  localparam logic [1:0] A_VEC  = 2'd2;
  localparam logic [1:0] A_EOI  = 2'd3;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] src_i;
  logic       sel_i;
  logic       we_i;
  logic [1:0] addr_i;
  logic [7:0] wdata_i;
  logic [7:0] rdata_o;
  logic       irq_o;

  typedef struct {
    string      name;
    logic [7:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  logic rd_fire;
  exp_t mon_e;

  irq_ctrl #(.NUM_SRC(8)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .src_i   (src_i),
    .sel_i   (sel_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .rdata_o (rdata_o),
    .irq_o   (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // Scoreboard monitor: a read seen at an edge produces rdata_o after it.
  initial begin
    forever begin
      @(posedge clk_i);
      rd_fire = sel_i && !we_i && !rst_i;
      #1;
      if (rd_fire) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_read: rdata_o=0x%02h with no expectation", rdata_o);
        end else begin
          mon_e = exp_q.pop_front();
          if (rdata_o !== mon_e.val) begin
            miscompares++;
            $display("FAIL %s: rdata_o=0x%02h required 0x%02h", mon_e.name, rdata_o, mon_e.val);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    sel_i   = 1'b1;
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    tick();
    sel_i   = 1'b0;
    we_i    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] exp_val, input string name);
    sel_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = a;
    exp_q.push_back('{name: name, val: exp_val});
    tick();
    sel_i  = 1'b0;
  endtask

  task automatic irq_is(input logic exp_val, input string name);
    vectors++;
    if (irq_o !== exp_val) begin
      miscompares++;
      $display("FAIL %s: irq_o=%b required %b", name, irq_o, exp_val);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #1;
    irq_is(1'b0, "reset_irq_initial");
    vectors++;
    if (rdata_o !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_rdata_initial: rdata_o=0x%02h required 0x00", rdata_o);
    end
    tick();
    tick();
    rst_i = 1'b0;
    tick();

    // Drive into ASSERT, then reset asynchronously between edges.
    wr(A_MASK, 8'h01);
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    tick();
    irq_is(1'b1, "reset_pre_assert");
    #2;
    rst_i = 1'b1;
    #1;
    irq_is(1'b0, "reset_async_irq");
    tick();
    rst_i = 1'b0;
    rd(A_PEND, 8'h00, "reset_pend");
    rd(A_MASK, 8'h00, "reset_mask");
    rd(A_VEC,  8'h00, "reset_vec");
    rd(A_EOI,  8'h00, "reset_insvc");
    tick();
    irq_is(1'b0, "reset_irq_after");
  endtask

  task automatic test_basic();
    wr(A_MASK, 8'h01);
    src_i = 8'h01;
    tick();
    src_i = 8'h00;
    irq_is(1'b0, "basic_irq_n1");
    tick();
    irq_is(1'b1, "basic_irq_n2");
    rd(A_VEC, 8'h80, "basic_vec");
    irq_is(1'b0, "basic_irq_after_ack");
    rd(A_EOI,  8'h01, "basic_insvc");
    rd(A_PEND, 8'h00, "basic_pend_acked");
    wr(A_EOI, 8'h00);
    tick();
    irq_is(1'b0, "basic_irq_after_eoi");
    rd(A_EOI, 8'h00, "basic_insvc_cleared");
    rd(A_VEC, 8'h00, "basic_vec_idle");
    rd(A_MASK, 8'h01, "basic_mask");
    tick();
    tick();
    tick();
    vectors++;
    if (rdata_o !== 8'h01) begin
      miscompares++;
      $display("FAIL basic_rdata_hold: rdata_o=0x%02h required 0x01", rdata_o);
    end
  endtask

  task automatic test_priority();
    wr(A_MASK, 8'hFF);
    src_i = 8'h28;
    tick();
    src_i = 8'h00;
    tick();
    irq_is(1'b1, "prio_irq");
    rd(A_VEC,  8'h83, "prio_vec_3");
    rd(A_PEND, 8'h20, "prio_pend_left");
    rd(A_EOI,  8'h08, "prio_insvc_3");
    wr(A_EOI, 8'h00);
    irq_is(1'b0, "prio_irq_eoi_n1");
    tick();
    irq_is(1'b1, "prio_irq_eoi_n2");
    // A higher-priority request arriving during ASSERT wins at the VEC read.
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    rd(A_VEC, 8'h82, "prio_late_winner");
    wr(A_EOI, 8'h00);
    tick();
    irq_is(1'b1, "prio_irq_reassert");
    rd(A_VEC, 8'h85, "prio_vec_5");
    wr(A_EOI, 8'h00);
    tick();
    irq_is(1'b0, "prio_irq_done");
    rd(A_PEND, 8'h00, "prio_pend_empty");
  endtask

  task automatic test_masking();
    wr(A_MASK, 8'h00);
    src_i = 8'h04;
    tick();
    tick();
    irq_is(1'b0, "mask_irq_masked");
    rd(A_PEND, 8'h04, "mask_pend_masked");
    wr(A_MASK, 8'h04);
    irq_is(1'b0, "mask_irq_n1");
    tick();
    irq_is(1'b1, "mask_irq_enabled");
    wr(A_MASK, 8'h00);
    irq_is(1'b0, "mask_irq_drop");
    // W1C while the source is still high.
    wr(A_PEND, 8'h04);
`ifdef IRQ_EDGE_EN
    rd(A_PEND, 8'h00, "mask_w1c_high_src");
`else
    rd(A_PEND, 8'h04, "mask_w1c_high_src");
`endif
    src_i = 8'h00;
    wr(A_PEND, 8'h04);
    rd(A_PEND, 8'h00, "mask_w1c_low_src");
    // W1C of the only candidate withdraws the request.
    wr(A_MASK, 8'h04);
    src_i = 8'h04;
    tick();
    src_i = 8'h00;
    tick();
    tick();
    irq_is(1'b1, "w1c_pre");
    wr(A_PEND, 8'h04);
    irq_is(1'b0, "w1c_drop");
    wr(A_MASK, 8'h00);
  endtask

  task automatic test_simultaneous();
    src_i = 8'h01;
    wr(A_PEND, 8'h01);
    src_i = 8'h00;
    rd(A_PEND, 8'h01, "sim_set_wins");
    wr(A_PEND, 8'h01);
    rd(A_PEND, 8'h00, "sim_cleared");
  endtask

  task automatic test_edge();
    src_i = 8'h02;
    tick();
    tick();
    wr(A_PEND, 8'h02);
    tick();
`ifdef IRQ_EDGE_EN
    rd(A_PEND, 8'h00, "edge_hold_w1c");
`else
    rd(A_PEND, 8'h02, "edge_hold_w1c");
`endif
    src_i = 8'h00;
    tick();
    wr(A_PEND, 8'h02);
    rd(A_PEND, 8'h00, "edge_low_clear");
    src_i = 8'h02;
    tick();
    src_i = 8'h00;
    rd(A_PEND, 8'h02, "edge_rerise");
    wr(A_PEND, 8'h02);
    rd(A_PEND, 8'h00, "edge_final_clear");
  endtask

  task automatic test_back_to_back();
    wr(A_MASK, 8'hA5);
    rd(A_MASK, 8'hA5, "b2b_mask");
    rd(A_PEND, 8'h00, "b2b_pend");
    rd(A_EOI,  8'h00, "b2b_insvc");
    wr(A_VEC,  8'hFF);
    rd(A_MASK, 8'hA5, "b2b_vec_write_ignored");
    wr(A_EOI,  8'h00);
    tick();
    irq_is(1'b0, "b2b_eoi_idle_ignored");
    wr(A_MASK, 8'h00);
    rd(A_MASK, 8'h00, "b2b_mask_zero");
  endtask

  initial begin
    rst_i   = 1'b1;
    src_i   = 8'h00;
    sel_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 2'd0;
    wdata_i = 8'h00;

    test_reset();
    test_basic();
    test_priority();
    test_masking();
    test_simultaneous();
    test_edge();
    test_back_to_back();

    tick();
    tick();
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d reads never produced data, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
